mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Round-robin arbiter and sequencer sharing one `mult` instance (8x8 -> 16 unsigned, start-by-`rst_i` / `busy_o` protocol) between N requesting datapath controllers, such as several accelerator FSMs. Each requester presents operands under a req/gnt/done handshake. The arbiter latches the operands, issues the one-cycle start pulse to `mult`, waits for `busy_o` to fall, and returns the 16-bit product with a one-cycle done pulse. It sits between the requesters' FSMs and the single multiplier.

## Interface
- `N`, default 2: number of requesters; legal range 2..4.
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `req_i`  in  N  per-requester operation request, level.
- `a_i`  in  8N  operand A per requester; slot k is bits [8k+7:8k].
- `b_i`  in  8N  operand B per requester; slot k is bits [8k+7:8k].
- `gnt_o`  out  N  one-hot; high from grant until the end of DONE.
- `done_o`  out  N  one-hot, one-cycle pulse; `y_o` is valid in the same cycle.
- `y_o`  out  16  last product; holds until the next completion.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `mult_rst_o`  out  1  start pulse to `mult` `rst_i`; registered.
- `mult_a_o`, `mult_b_o`  out  8 each  registered operands to `mult`.
- `mult_busy_i`  in  1  `mult` `busy_o`.
- `mult_y_i`  in  16  `mult` `y_bo`.

## Operation
- **Reset.** While `rst_n_i` is low, all outputs are 0, the state is IDLE and the pointer is 0. The clear is immediate, not clock-gated.
- **Priority.** After serving k, the priority order is k+1, k+2, …, k (mod N). After reset, index 0 has top priority.
- **IDLE.**
  - If `req_i` is 0: stay in IDLE.
  - Otherwise pick the winner w by the priority rule and register the following:
    - `gnt_o[w]`=1.
    - `mult_a_o`=a slot w, `mult_b_o`=b slot w.
    - `mult_rst_o`=1.
  - Go to START.
- **START (exactly 1 cycle).** Register `mult_rst_o`=0 and go to WAIT. The operands stay stable until the next grant.
- **WAIT.**
  - While `mult_busy_i`=1: stay in WAIT.
  - When `mult_busy_i`=0: register `y_o`=`mult_y_i` and `done_o[w]`=1, then go to DONE.
- **DONE (1 cycle).**
  - Register `done_o`=0 and `gnt_o`=0.
  - Set pointer = (w+1) mod N.
  - Go to IDLE.
- **Multiplier contract.** `mult` must assert `busy_o` in the cycle after `rst_i` was high (the first WAIT cycle). The arbiter does not mask that first WAIT cycle.
- **Requester contract.** Hold `req_i` and the operands stable until the IDLE cycle that samples the request; the operands are latched at grant.
  - A `req_i` still high at the next IDLE is a new request.
  - A requester wanting one operation drops `req_i` no later than the cycle `done_o` is high.
- **Dropped request.** Deasserting `req_i` after grant does not abort the operation. It completes and `done_o` still pulses.
- **Simultaneous events.** Requests arriving during START, WAIT or DONE wait; they are only sampled in IDLE.
- **Reset mid-operation.** All arbiter state and outputs clear asynchronously, and no done is issued. `mult` is not reset by the arbiter. The next grant's start pulse restarts `mult`, and any stale result is never forwarded.
- **Arithmetic.** Unsigned throughout. `y_o` is the 16-bit `mult_y_i`, passed through with no truncation.

## Timing
- Cycle T: IDLE samples `req_i`.
- T+1: START; `mult_rst_o`=1 and `gnt_o` valid.
- T+2 onward: WAIT.
- If `mult_busy_i` is high for L cycles (T+2..T+L+1), then `done_o` and `y_o` are valid in cycle T+L+3 and the DONE state is cycle T+L+3.
- The next IDLE sample is at T+L+4, so back-to-back throughput is one operation per L+4 cycles.
- `gnt_o` is high from T+1 through T+L+3 inclusive.
- `busy_o` is high from T+1 through T+L+3 inclusive.
- `mult_rst_o` is high in exactly one cycle per operation.
- At most one bit of `gnt_o` or `done_o` is ever high.

## Test plan
- **Single request.** Bench `mult` model holds busy for 8 cycles. After reset, `req_i`=01, a0=12, b0=11 -> `gnt_o`=01 at T+1, `mult_rst_o` one pulse with `mult_a_o`=12 and `mult_b_o`=11, `done_o`=01 at T+11, `y_o`=132, `busy_o` low at T+12.
- **Simultaneous requests after reset.** `req_i`=11, a0=3, b0=5, a1=7, b1=9 -> requester 0 served first (`y_o`=15), then requester 1 (`y_o`=63) with its grant at T+13; grants never overlap.
- **Fairness under saturation.** Both requests held high for 4 operations -> grant order 0,1,0,1 and exactly 4 `done_o` pulses.
- **Extreme operands.** 255*255 -> `y_o`=65025 (0xFE01); 0*200 -> `y_o`=0; 1*255 -> `y_o`=255.
- **Reset mid-WAIT.** `rst_n_i` low in the 3rd WAIT cycle -> `gnt_o`, `done_o`, `busy_o` and `mult_rst_o` go to 0 before the next edge and no done is issued. After release, `req_i`=10, a1=20, b1=10 -> a fresh start pulse and `y_o`=200.
- **Request dropped during WAIT.** `req_i[0]` falls during WAIT -> `done_o[0]` still pulses with the correct product, and there is no re-grant afterwards.

Source files
------------

// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - requester-side req/gnt/done bus shared by N controllers
interface mult_arbiter_if #(parameter int N = 2);
    logic [N-1:0]   req;
    logic [8*N-1:0] a;
    logic [8*N-1:0] b;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [15:0]    y;

    modport master (output req, a, b, input gnt, done, y);
    modport slave  (input req, a, b, output gnt, done, y);
endinterface

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sequencing N requesters onto one shared mult
module mult_arbiter #(
    parameter int N = 2
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    mult_arbiter_if.slave rq,
    output logic          busy_o,
    output logic          mult_rst_o,
    output logic [7:0]    mult_a_o,
    output logic [7:0]    mult_b_o,
    input  logic          mult_busy_i,
    input  logic [15:0]   mult_y_i
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  win_q, win_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [N-1:0] done_q, done_d;
    logic [15:0] y_q, y_d;
    logic        mult_rst_q, mult_rst_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;

    // Widened copies let a 2-bit index address any slot for every legal N.
    logic [3:0]  req_ext;
    logic [31:0] a_ext;
    logic [31:0] b_ext;
    logic [3:0]  pick_onehot;
    logic        found;
    logic [1:0]  pick;
    logic [2:0]  cand;
    logic [2:0]  ptr_next;

    assign req_ext     = 4'(rq.req);
    assign a_ext       = 32'(rq.a);
    assign b_ext       = 32'(rq.b);
    assign pick_onehot = 4'b0001 << pick;

    always_comb begin : pick_winner
        found = 1'b0;
        pick  = ptr_q;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + 3'(i);
            if (cand >= 3'(N)) cand = cand - 3'(N);
            if (!found && req_ext[cand[1:0]]) begin
                found = 1'b1;
                pick  = cand[1:0];
            end
        end
    end

    always_comb begin : next_ptr
        ptr_next = {1'b0, win_q} + 3'd1;
        if (ptr_next >= 3'(N)) ptr_next = '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            y_q        <= '0;
            mult_rst_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            y_q        <= y_d;
            mult_rst_q <= mult_rst_d;
            a_q        <= a_d;
            b_q        <= b_d;
        end
    end

    always_comb begin : fsm
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        gnt_d      = gnt_q;
        done_d     = done_q;
        y_d        = y_q;
        mult_rst_d = mult_rst_q;
        a_d        = a_q;
        b_d        = b_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d      = pick;
                    gnt_d      = pick_onehot[N-1:0];
                    a_d        = a_ext[{pick, 3'b000} +: 8];
                    b_d        = b_ext[{pick, 3'b000} +: 8];
                    mult_rst_d = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                mult_rst_d = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // The grant vector already encodes the winner as one-hot.
                if (!mult_busy_i) begin
                    y_d     = mult_y_i;
                    done_d  = gnt_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = '0;
                gnt_d   = '0;
                ptr_d   = ptr_next[1:0];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rq.gnt     = gnt_q;
    assign rq.done    = done_q;
    assign rq.y       = y_q;
    assign busy_o     = (state_q != S_IDLE);
    assign mult_rst_o = mult_rst_q;
    assign mult_a_o   = a_q;
    assign mult_b_o   = b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench for mult_arbiter with a fixed-latency mult model
module tb_mult_arbiter;
    localparam int N = 2;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        busy_o;
    logic        mult_rst_o;
    logic [7:0]  mult_a_o;
    logic [7:0]  mult_b_o;
    logic        mult_busy_i;
    logic [15:0] mult_y_i;

    always #5 clk_i = ~clk_i;

    mult_arbiter_if #(.N(N)) rq ();

    mult_arbiter #(.N(N)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .rq          (rq),
        .busy_o      (busy_o),
        .mult_rst_o  (mult_rst_o),
        .mult_a_o    (mult_a_o),
        .mult_b_o    (mult_b_o),
        .mult_busy_i (mult_busy_i),
        .mult_y_i    (mult_y_i)
    );

    // mult model: busy for 8 cycles after a start pulse, garbage output while busy
    int unsigned mcnt  = 0;
    logic [15:0] mprod = 16'd0;
    always_ff @(posedge clk_i) begin
        if (mult_rst_o) begin
            mcnt  <= 8;
            mprod <= {8'd0, mult_a_o} * {8'd0, mult_b_o};
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
        end
    end
    assign mult_busy_i = (mcnt != 0);
    assign mult_y_i    = (mcnt != 0) ? 16'hDEAD : mprod;

    typedef struct packed {
        logic [N-1:0] done;
        logic [15:0]  y;
    } exp_t;

    typedef struct {
        int          idx;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] y;
    } vec_t;

    exp_t sb[$];
    int   gnt_order[$];
    int   checks    = 0;
    int   errors    = 0;
    int   done_cnt  = 0;
    int   mrst_cnt  = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void push_exp(int idx, logic [15:0] y);
        exp_t e;
        e.done = N'(1 << idx);
        e.y    = y;
        sb.push_back(e);
    endfunction

    initial begin : monitor
        exp_t         e;
        logic [N-1:0] gnt_prev;
        gnt_prev = '0;
        forever begin
            @(negedge clk_i);
            chk("gnt_onehot", 32'($onehot0(rq.gnt)), 32'd1);
            chk("done_onehot", 32'($onehot0(rq.done)), 32'd1);
            if (mult_rst_o) mrst_cnt++;
            if (rq.done != '0) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=%0d expected none", rq.done);
                end else begin
                    e = sb.pop_front();
                    chk("done_idx", 32'(rq.done), 32'(e.done));
                    chk("y", 32'(rq.y), 32'(e.y));
                end
            end
            if (rq.gnt != '0 && gnt_prev == '0)
                for (int i = 0; i < N; i++) if (rq.gnt[i]) gnt_order.push_back(i);
            gnt_prev = rq.gnt;
        end
    end

    task automatic do_reset();
        rq.req  = '0;
        rq.a    = '0;
        rq.b    = '0;
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic run_op(int idx, logic [7:0] a, logic [7:0] b, logic [15:0] ey);
        int d0, m0, n;
        rq.a[8*idx +: 8] = a;
        rq.b[8*idx +: 8] = b;
        push_exp(idx, ey);
        d0 = done_cnt;
        m0 = mrst_cnt;
        rq.req = N'(1 << idx);
        n = 0;
        while (rq.gnt == '0 && n < 50) begin @(negedge clk_i); n++; end
        chk("op_gnt", 32'(rq.gnt), 32'(1 << idx));
        rq.req = '0;
        n = 0;
        while (done_cnt == d0 && n < 50) begin @(negedge clk_i); n++; end
        chk("op_done_seen", 32'(done_cnt - d0), 32'd1);
        n = 0;
        while (busy_o && n < 20) begin @(negedge clk_i); n++; end
        chk("op_idle", 32'(busy_o), 32'd0);
        chk("op_start_pulses", 32'(mrst_cnt - m0), 32'd1);
    endtask

    initial begin : main
        vec_t vt[6];
        int   d0, nd, ng, n;

        vt[0] = '{idx: 0, a: 8'd12,  b: 8'd11,  y: 16'd132};
        vt[1] = '{idx: 0, a: 8'd255, b: 8'd255, y: 16'hFE01};
        vt[2] = '{idx: 1, a: 8'd0,   b: 8'd200, y: 16'd0};
        vt[3] = '{idx: 1, a: 8'd1,   b: 8'd255, y: 16'd255};
        vt[4] = '{idx: 0, a: 8'd3,   b: 8'd5,   y: 16'd15};
        vt[5] = '{idx: 1, a: 8'd7,   b: 8'd9,   y: 16'd63};

        rq.req  = '0;
        rq.a    = '0;
        rq.b    = '0;
        rst_n_i = 1'b0;
        @(negedge clk_i);
        chk("rst_gnt", 32'(rq.gnt), 0);
        chk("rst_done", 32'(rq.done), 0);
        chk("rst_y", 32'(rq.y), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_mult_rst", 32'(mult_rst_o), 0);
        chk("rst_mult_a", 32'(mult_a_o), 0);
        chk("rst_mult_b", 32'(mult_b_o), 0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // single request, cycle-accurate timing
        rq.a   = {8'd0, 8'd12};
        rq.b   = {8'd0, 8'd11};
        rq.req = 2'b01;
        push_exp(0, 16'd132);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_i);
            if (k == 1) begin
                chk("t1_gnt", 32'(rq.gnt), 32'd1);
                chk("t1_mult_rst", 32'(mult_rst_o), 32'd1);
                chk("t1_mult_a", 32'(mult_a_o), 32'd12);
                chk("t1_mult_b", 32'(mult_b_o), 32'd11);
                chk("t1_busy", 32'(busy_o), 32'd1);
                rq.req = '0;
            end
            if (k == 2)  chk("t2_mult_rst", 32'(mult_rst_o), 32'd0);
            if (k == 10) chk("t10_done", 32'(rq.done), 32'd0);
            if (k == 11) begin
                chk("t11_done", 32'(rq.done), 32'd1);
                chk("t11_y", 32'(rq.y), 32'd132);
                chk("t11_gnt", 32'(rq.gnt), 32'd1);
            end
            if (k == 12) begin
                chk("t12_busy", 32'(busy_o), 32'd0);
                chk("t12_gnt", 32'(rq.gnt), 32'd0);
                chk("t12_y_hold", 32'(rq.y), 32'd132);
            end
        end

        for (int i = 0; i < 6; i++) run_op(vt[i].idx, vt[i].a, vt[i].b, vt[i].y);

        // simultaneous requests after reset: 0 first, then 1 granted at T+13
        do_reset();
        rq.a = {8'd7, 8'd3};
        rq.b = {8'd9, 8'd5};
        push_exp(0, 16'd15);
        push_exp(1, 16'd63);
        rq.req = 2'b11;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk_i);
            if (k == 1) begin
                chk("sim_first_gnt", 32'(rq.gnt), 32'd1);
                rq.req = 2'b10;
            end
            if (k == 12) chk("sim_gap_gnt", 32'(rq.gnt), 32'd0);
            if (k == 13) begin
                chk("sim_second_gnt", 32'(rq.gnt), 32'd2);
                chk("sim_second_a", 32'(mult_a_o), 32'd7);
                rq.req = '0;
            end
        end

        // fairness under saturation
        do_reset();
        rq.a = {8'd30, 8'd10};
        rq.b = {8'd40, 8'd20};
        for (int i = 0; i < 2; i++) begin
            push_exp(0, 16'd200);
            push_exp(1, 16'd1200);
        end
        gnt_order.delete();
        d0 = done_cnt;
        nd = 0;
        n  = 0;
        rq.req = 2'b11;
        while (nd < 4 && n < 200) begin
            @(negedge clk_i);
            n++;
            if (rq.done != '0) nd++;
            if (nd == 4) rq.req = '0;
        end
        rq.req = '0;
        repeat (15) @(negedge clk_i);
        chk("fair_dones", 32'(done_cnt - d0), 32'd4);
        chk("fair_grants", 32'(gnt_order.size()), 32'd4);
        if (gnt_order.size() >= 4)
            for (int i = 0; i < 4; i++) chk("fair_order", 32'(gnt_order[i]), 32'(i % 2));

        // reset in the third WAIT cycle
        do_reset();
        rq.a   = {8'd0, 8'd50};
        rq.b   = {8'd0, 8'd2};
        rq.req = 2'b01;
        d0 = done_cnt;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i);
            if (k == 1) rq.req = '0;
        end
        chk("rw_busy_before", 32'(busy_o), 32'd1);
        rst_n_i = 1'b0;
        #1;
        chk("rw_gnt", 32'(rq.gnt), 0);
        chk("rw_done", 32'(rq.done), 0);
        chk("rw_busy", 32'(busy_o), 0);
        chk("rw_mult_rst", 32'(mult_rst_o), 0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (15) @(negedge clk_i);
        chk("rw_no_done", 32'(done_cnt - d0), 32'd0);
        rq.a   = {8'd20, 8'd0};
        rq.b   = {8'd10, 8'd0};
        rq.req = 2'b10;
        push_exp(1, 16'd200);
        @(negedge clk_i);
        chk("rw_restart_pulse", 32'(mult_rst_o), 32'd1);
        chk("rw_restart_gnt", 32'(rq.gnt), 32'd2);
        rq.req = '0;
        n = 0;
        while (done_cnt == d0 && n < 30) begin @(negedge clk_i); n++; end
        chk("rw_fresh_done", 32'(done_cnt - d0), 32'd1);

        // request dropped during WAIT still completes, no re-grant
        repeat (3) @(negedge clk_i);
        rq.a   = {8'd0, 8'd9};
        rq.b   = {8'd0, 8'd9};
        rq.req = 2'b01;
        push_exp(0, 16'd81);
        d0 = done_cnt;
        ng = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_i);
            if (k == 4) rq.req = '0;
            if (k >= 12 && rq.gnt != '0) ng++;
        end
        chk("drop_done", 32'(done_cnt - d0), 32'd1);
        chk("drop_no_regrant", 32'(ng), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
